// File: rtl/vdo_pkg.sv
// Shared video types for the HDMI RX -> CSI-2 TX path.
// Format detection and the stream gate both use these types.
package vdo_pkg;

    localparam int VDO_DATA_W = 48;

    typedef enum logic [1:0] {
        NOVIDEO   = 2'b00,
        P60AT1080 = 2'b01,
        P30AT4K   = 2'b10,
        P60AT4K   = 2'b11
    } frame_fmt_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        PASS     = 2'd2,
        DRAIN    = 2'd3
    } gate_state_t;

endpackage

// File: rtl/vdo_axis_out_reg.sv
// Single-stage AXI4-Stream register.
// Data is held while the output is stalled, and valid is never retracted.
module vdo_axis_out_reg
    import vdo_pkg::*;
#(
    parameter int DATA_W = VDO_DATA_W
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              in_user,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_user,
    input  logic              out_ready
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_user  <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_last  <= in_last;
            out_user  <= in_user;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/vdo_stream_gate.sv
// Frame-aligned video gate: passes whole frames only after the format has been stable.
// Outside PASS the input is always accepted and discarded, so the RX side never stalls.
module vdo_stream_gate
    import vdo_pkg::*;
#(
    parameter int DATA_W      = VDO_DATA_W,
    parameter int STABLE_SECS = 2
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [DATA_W-1:0] s_axis_video_tdata,
    input  logic              s_axis_video_tvalid,
    output logic              s_axis_video_tready,
    input  logic              s_axis_video_tlast,
    input  logic              s_axis_video_tuser,
    input  logic [1:0]        frameFormat,
    input  logic              oneSecPulse,
    output logic [DATA_W-1:0] m_axis_video_tdata,
    output logic              m_axis_video_tvalid,
    input  logic              m_axis_video_tready,
    output logic              m_axis_video_tlast,
    output logic              m_axis_video_tuser,
    output logic [1:0]        gateState,
    output logic              fmtLocked,
    output logic [15:0]       dropFrameCnt,
    output logic [7:0]        fmtChangeCnt
);

    localparam int SW = $clog2(STABLE_SECS + 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_SECS);

    gate_state_t   state, stateNext;
    frame_fmt_t    curFmt, lastFmt;
    logic [SW-1:0] stableCnt;
    logic          fmtChg;
    logic          sReady, regInReady;
    logic          sAccept, sofAccept;
    logic          loadBeat, dropSof;

    assign curFmt    = frame_fmt_t'(frameFormat);
    assign fmtChg    = (curFmt != lastFmt);
    assign fmtLocked = (stableCnt == STABLE_MAX);
    assign gateState = state;

    // Reset forces every output low, including the otherwise always-high discard ready.
    assign s_axis_video_tready = aresetn && sReady;
    assign sAccept   = s_axis_video_tvalid && s_axis_video_tready;
    assign sofAccept = sAccept && s_axis_video_tuser;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            lastFmt      <= NOVIDEO;
            stableCnt    <= '0;
            fmtChangeCnt <= '0;
            dropFrameCnt <= '0;
        end else begin
            lastFmt <= curFmt;
            if (fmtChg) begin
                fmtChangeCnt <= fmtChangeCnt + 8'd1;
                stableCnt    <= '0;
            end else if (oneSecPulse && curFmt != NOVIDEO && stableCnt != STABLE_MAX) begin
                stableCnt <= stableCnt + 1'b1;
            end
            if (dropSof && dropFrameCnt != 16'hFFFF) begin
                dropFrameCnt <= dropFrameCnt + 16'd1;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // A format change on the same cycle as a WAIT_SOF start-of-frame wins: that frame is dropped.
    always_comb begin
        stateNext = state;
        loadBeat  = 1'b0;
        dropSof   = 1'b0;
        sReady    = 1'b1;
        case (state)
            IDLE: begin
                dropSof = sofAccept;
                if (fmtLocked) begin
                    stateNext = WAIT_SOF;
                end
            end
            WAIT_SOF: begin
                if (!fmtLocked || fmtChg) begin
                    dropSof   = sofAccept;
                    stateNext = IDLE;
                end else if (sofAccept) begin
                    loadBeat  = 1'b1;
                    stateNext = PASS;
                end
            end
            PASS: begin
                sReady   = regInReady;
                loadBeat = sAccept;
                if (fmtChg || curFmt == NOVIDEO) begin
                    stateNext = DRAIN;
                end
            end
            DRAIN: begin
                dropSof = sofAccept;
                if (!m_axis_video_tvalid) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    vdo_axis_out_reg #(
        .DATA_W(DATA_W)
    ) u_out_reg (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .in_valid  (loadBeat),
        .in_data   (s_axis_video_tdata),
        .in_last   (s_axis_video_tlast),
        .in_user   (s_axis_video_tuser),
        .in_ready  (regInReady),
        .out_valid (m_axis_video_tvalid),
        .out_data  (m_axis_video_tdata),
        .out_last  (m_axis_video_tlast),
        .out_user  (m_axis_video_tuser),
        .out_ready (m_axis_video_tready)
    );

endmodule

// File: tb/tb_vdo_stream_gate.sv
// Directed bench for vdo_stream_gate: frames of 4 lines x 8 beats with hand-computed expectations.
module tb_vdo_stream_gate;

    localparam int DW = 48;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic          s_tlast = 1'b0;
    logic          s_tuser = 1'b0;
    logic [1:0]    frameFormat = 2'b00;
    logic          oneSecPulse = 1'b0;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic          m_tlast;
    logic          m_tuser;
    logic [1:0]    gateState;
    logic          fmtLocked;
    logic [15:0]   dropFrameCnt;
    logic [7:0]    fmtChangeCnt;

    int errors = 0;
    int checks = 0;

    logic [DW+1:0] outQ[$];
    logic          prevStall = 1'b0;
    logic [DW+1:0] prevBeat = '0;
    int            stallErr = 0;
    int            stallCount = 0;
    logic          readyMode = 1'b0;
    logic [3:0]    readyPat = 4'b1001;
    int            patIdx = 0;
    logic          readyWindow = 1'b0;
    int            notReadyCnt = 0;

    always #5 aclk = ~aclk;

    vdo_stream_gate dut (
        .aclk                (aclk),
        .aresetn             (aresetn),
        .s_axis_video_tdata  (s_tdata),
        .s_axis_video_tvalid (s_tvalid),
        .s_axis_video_tready (s_tready),
        .s_axis_video_tlast  (s_tlast),
        .s_axis_video_tuser  (s_tuser),
        .frameFormat         (frameFormat),
        .oneSecPulse         (oneSecPulse),
        .m_axis_video_tdata  (m_tdata),
        .m_axis_video_tvalid (m_tvalid),
        .m_axis_video_tready (m_tready),
        .m_axis_video_tlast  (m_tlast),
        .m_axis_video_tuser  (m_tuser),
        .gateState           (gateState),
        .fmtLocked           (fmtLocked),
        .dropFrameCnt        (dropFrameCnt),
        .fmtChangeCnt        (fmtChangeCnt)
    );

    // Sink ready: always high, or the repeating 1,0,0,1 stall pattern.
    always @(posedge aclk) begin
        #2;
        if (readyMode) begin
            m_tready = readyPat[patIdx];
            patIdx   = (patIdx + 1) % 4;
        end else begin
            m_tready = 1'b1;
        end
    end

    // Mid-cycle monitor: records output handshakes and watches stall stability.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (prevStall && (m_tvalid !== 1'b1 || {m_tlast, m_tuser, m_tdata} !== prevBeat))
                stallErr++;
            if (m_tvalid && m_tready)
                outQ.push_back({m_tlast, m_tuser, m_tdata});
            prevStall = m_tvalid && !m_tready;
            prevBeat  = {m_tlast, m_tuser, m_tdata};
            if (prevStall)
                stallCount++;
            if (readyWindow && !s_tready)
                notReadyCnt++;
        end else begin
            prevStall = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [DW-1:0] beatData(input int fid, input int idx);
        return {16'(fid), 16'(idx / 8), 16'(idx % 8)};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge aclk);
        #2;
    endtask

    task automatic pulseSec();
        @(posedge aclk);
        #2 oneSecPulse = 1'b1;
        @(posedge aclk);
        #2 oneSecPulse = 1'b0;
    endtask

    task automatic sendBeat(input logic [DW-1:0] d, input logic l, input logic u);
        int n = 0;
        s_tdata  = d;
        s_tlast  = l;
        s_tuser  = u;
        s_tvalid = 1'b1;
        @(negedge aclk);
        while (!s_tready && n < 200) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 200)
            checkOutput("s_tready_timeout", 64'd0, 64'd1);
        @(posedge aclk);
        #2 s_tvalid = 1'b0;
    endtask

    // Sends linear beat indices first..last of frame fid; optionally changes format at chgIdx.
    task automatic applyStimulus(input int fid, input int first, input int last,
                                 input int chgIdx, input logic [1:0] newFmt);
        for (int i = first; i <= last; i++) begin
            if (i == chgIdx)
                frameFormat = newFmt;
            sendBeat(beatData(fid, i), (i % 8) == 7, i == 0);
            if (i == chgIdx)
                checkOutput("drain_entered", 64'(gateState), 64'd3);
        end
    endtask

    task automatic waitDrain();
        int n = 0;
        while (m_tvalid && n < 100) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 100)
            checkOutput("drain_timeout", 64'd1, 64'd0);
        idleCycles(1);
    endtask

    task automatic checkSeq(input string tag, input int qStart, input int fid, input int count);
        int errs = 0;
        logic [DW+1:0] exp;
        if (outQ.size() < qStart + count) begin
            errs = count;
        end else begin
            for (int i = 0; i < count; i++) begin
                exp = {(i % 8) == 7, i == 0, beatData(fid, i)};
                if (outQ[qStart + i] !== exp)
                    errs++;
            end
        end
        checkOutput(tag, 64'(errs), 64'd0);
    endtask

    initial begin
        int baseDrop;
        int baseChg;

        // Reset state
        #23;
        checkOutput("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        checkOutput("rst_s_tready", 64'(s_tready), 64'd0);
        checkOutput("rst_state", 64'(gateState), 64'd0);
        checkOutput("rst_locked", 64'(fmtLocked), 64'd0);
        checkOutput("rst_drop", 64'(dropFrameCnt), 64'd0);
        checkOutput("rst_fmtchg", 64'(fmtChangeCnt), 64'd0);
        @(posedge aclk);
        #2 aresetn = 1'b1;
        idleCycles(2);

        // Test 1: lock on 1080p60, one pre-lock frame dropped, then 3 frames forwarded
        $display("[TB] test 1: lock and forward");
        frameFormat = 2'b01;
        idleCycles(2);
        checkOutput("t1_fmtchg", 64'(fmtChangeCnt), 64'd1);
        applyStimulus(1, 0, 31, -1, 2'b00);
        pulseSec();
        checkOutput("t1_locked_p1", 64'(fmtLocked), 64'd0);
        pulseSec();
        checkOutput("t1_locked_p2", 64'(fmtLocked), 64'd1);
        idleCycles(2);
        checkOutput("t1_wait_sof", 64'(gateState), 64'd1);
        for (int f = 2; f <= 4; f++)
            applyStimulus(f, 0, 31, -1, 2'b00);
        waitDrain();
        checkOutput("t1_beats", 64'(outQ.size()), 64'd96);
        checkOutput("t1_first_tuser", 64'(outQ.size() > 0 ? outQ[0][DW] : 1'b0), 64'd1);
        checkSeq("t1_seq_f2", 0, 2, 32);
        checkSeq("t1_seq_f4", 64, 4, 32);
        checkOutput("t1_drop", 64'(dropFrameCnt), 64'd1);
        checkOutput("t1_state_pass", 64'(gateState), 64'd2);

        // Test 2: 01 -> 11 at line 2 beat 3
        $display("[TB] test 2: format change mid-frame");
        outQ.delete();
        baseChg = int'(fmtChangeCnt);
        applyStimulus(5, 0, 31, 11, 2'b11);
        waitDrain();
        checkOutput("t2_beats", 64'(outQ.size()), 64'd12);
        checkSeq("t2_seq", 0, 5, 12);
        checkOutput("t2_state_idle", 64'(gateState), 64'd0);
        checkOutput("t2_fmtchg_delta", 64'(int'(fmtChangeCnt) - baseChg), 64'd1);
        applyStimulus(6, 0, 31, -1, 2'b00);
        pulseSec();
        applyStimulus(7, 0, 31, -1, 2'b00);
        checkOutput("t2_locked_p1", 64'(fmtLocked), 64'd0);
        checkOutput("t2_no_output", 64'(outQ.size()), 64'd12);
        pulseSec();
        idleCycles(2);
        applyStimulus(8, 0, 31, -1, 2'b00);
        waitDrain();
        checkOutput("t2_relock_beats", 64'(outQ.size()), 64'd44);
        checkSeq("t2_relock_seq", 12, 8, 32);
        checkOutput("t2_drop", 64'(dropFrameCnt), 64'd3);

        // Test 3: back-pressure 1,0,0,1
        $display("[TB] test 3: output back-pressure");
        outQ.delete();
        stallErr   = 0;
        stallCount = 0;
        readyMode  = 1'b1;
        applyStimulus(10, 0, 31, -1, 2'b00);
        applyStimulus(11, 0, 31, -1, 2'b00);
        waitDrain();
        readyMode = 1'b0;
        idleCycles(2);
        checkOutput("t3_beats", 64'(outQ.size()), 64'd64);
        checkSeq("t3_seq_f10", 0, 10, 32);
        checkSeq("t3_seq_f11", 32, 11, 32);
        checkOutput("t3_stall_stable", 64'(stallErr), 64'd0);
        checkOutput("t3_stalls_seen", 64'(stallCount > 0), 64'd1);

        // Test 5: reset pulsed mid-line while passing
        $display("[TB] test 5: reset mid-frame");
        outQ.delete();
        applyStimulus(30, 0, 10, -1, 2'b00);
        aresetn = 1'b0;
        #1;
        checkOutput("t5_m_tvalid", 64'(m_tvalid), 64'd0);
        checkOutput("t5_state", 64'(gateState), 64'd0);
        checkOutput("t5_drop", 64'(dropFrameCnt), 64'd0);
        checkOutput("t5_s_tready", 64'(s_tready), 64'd0);
        idleCycles(2);
        aresetn = 1'b1;
        idleCycles(2);
        checkOutput("t5_state_idle", 64'(gateState), 64'd0);
        checkOutput("t5_fmtchg", 64'(fmtChangeCnt), 64'd1);
        applyStimulus(30, 11, 31, -1, 2'b00);
        checkOutput("t5_no_resume", 64'(outQ.size()), 64'd10);
        pulseSec();
        pulseSec();
        idleCycles(2);
        applyStimulus(31, 0, 31, -1, 2'b00);
        waitDrain();
        checkOutput("t5_beats", 64'(outQ.size()), 64'd42);
        checkOutput("t5_first_tuser", 64'(outQ.size() > 10 ? outQ[10][DW] : 1'b0), 64'd1);
        checkSeq("t5_seq", 10, 31, 32);

        // Test 4: no video for 3 pulses
        $display("[TB] test 4: no format");
        frameFormat = 2'b00;
        idleCycles(3);
        waitDrain();
        idleCycles(3);
        outQ.delete();
        baseDrop    = int'(dropFrameCnt);
        notReadyCnt = 0;
        readyWindow = 1'b1;
        for (int f = 40; f < 43; f++) begin
            applyStimulus(f, 0, 31, -1, 2'b00);
            pulseSec();
        end
        readyWindow = 1'b0;
        checkOutput("t4_s_tready", 64'(notReadyCnt), 64'd0);
        checkOutput("t4_no_output", 64'(outQ.size()), 64'd0);
        checkOutput("t4_drop_delta", 64'(int'(dropFrameCnt) - baseDrop), 64'd3);
        checkOutput("t4_locked", 64'(fmtLocked), 64'd0);
        checkOutput("t4_state", 64'(gateState), 64'd0);

        // Test 6: format change on the same cycle as the SOF in WAIT_SOF
        $display("[TB] test 6: change with SOF");
        frameFormat = 2'b01;
        idleCycles(2);
        pulseSec();
        pulseSec();
        idleCycles(2);
        checkOutput("t6_wait_sof", 64'(gateState), 64'd1);
        baseDrop = int'(dropFrameCnt);
        frameFormat = 2'b10;
        sendBeat(beatData(50, 0), 1'b0, 1'b1);
        checkOutput("t6_state", 64'(gateState), 64'd0);
        idleCycles(3);
        checkOutput("t6_drop_delta", 64'(int'(dropFrameCnt) - baseDrop), 64'd1);
        checkOutput("t6_no_output", 64'(outQ.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
